// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer
// Description : 320x240 RGB332 pixel store between the rasterizer (write
//               port) and VGA scan-out (read port). The stored byte is
//               decoded to 4-bit R/G/B, and a clear engine can fill the whole
//               buffer with one colour.
// Ports       : pixel_clk      - sole clock, rising edge
//               arstn          - synchronous active-low reset (memory kept)
//               wea/addra/dina - rasterizer write port
//               addrb          - scan-out read address
//               doutb          - registered read data, 1-cycle latency
//               red/green/blue - 4-bit channels decoded from doutb
//               clr_req        - one-cycle pulse that starts a full clear
//               clr_color      - fill value, sampled when clr_req is accepted
//               clr_busy       - high while the clear engine owns the write port
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer #(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240,
    parameter int unsigned DEPTH = H_RES * V_RES,
    parameter int unsigned AW    = 17,
    parameter int unsigned DW    = 8
) (
    input  logic          pixel_clk,
    input  logic          arstn,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] doutb,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue,
    input  logic          clr_req,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy
);

    // Address limits are held one bit wider than the address so that
    // DEPTH == 2**AW remains representable.
    localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_one   = AW'(1);

    // Clear engine states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DW-1:0] mem [0:DEPTH-1];

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [DW-1:0] r_clr_color;
    logic [DW-1:0] r_doutb;

    logic          w_clr_start;
    logic          w_clr_we;
    logic          w_clr_last;
    logic          w_busy;

    logic          w_addra_ok;
    logic          w_addrb_ok;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_din;

    assign w_addra_ok = ({1'b0, addra} < c_depth);
    assign w_addrb_ok = ({1'b0, addrb} < c_depth);
    assign w_clr_last = (r_clr_cnt == c_last);

    // ------------------------------------------------------------------------
    // Clear FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Clear FSM: next-state logic. A request during FILL is simply not
    // looked at, so it neither restarts nor queues a clear.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (w_clr_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Clear FSM: outputs. Busy is a decode of the registered state, so it
    // rises the edge after the request and falls on the edge that performs
    // the final fill write: exactly DEPTH cycles high.
    // ------------------------------------------------------------------------
    always_comb begin
        w_clr_start = 1'b0;
        w_clr_we    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr_start = clr_req;
            end
            S_FILL: begin
                w_clr_we = 1'b1;
                w_busy   = 1'b1;
            end
            default: begin
                w_clr_start = 1'b0;
            end
        endcase
    end

    assign clr_busy = w_busy;

    // ------------------------------------------------------------------------
    // Clear datapath: fill colour and address counter
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
        end else if (w_clr_start) begin
            r_clr_cnt   <= '0;
            r_clr_color <= clr_color;
        end else if (w_clr_we) begin
            if (w_clr_last) begin
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + c_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write port arbitration. The clear engine has sole ownership during
    // FILL; user writes in that window are dropped. In the IDLE cycle that
    // accepts a clear the user write still lands, and is later overwritten.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = addra;
        w_mem_din  = dina;
        if (arstn) begin
            if (w_clr_we) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_cnt;
                w_mem_din  = r_clr_color;
            end else if (wea && w_addra_ok) begin
                w_mem_we = 1'b1;
            end
        end
    end

    // Memory write: no reset so the array maps onto block RAM.
    always_ff @(posedge pixel_clk) begin
        if (w_mem_we) begin
            mem[w_mem_addr] <= w_mem_din;
        end
    end

    // ------------------------------------------------------------------------
    // Read port: registered, active every cycle. Non-blocking update of the
    // array gives read-first behaviour on an address collision.
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            r_doutb <= '0;
        end else if (w_addrb_ok) begin
            r_doutb <= mem[addrb];
        end else begin
            r_doutb <= '0;
        end
    end

    assign doutb = r_doutb;

    // RGB332 expanded to 4 bits per channel with zero LSB padding.
    assign red   = {r_doutb[7:5], 1'b0};
    assign green = {r_doutb[4:2], 1'b0};
    assign blue  = {r_doutb[1:0], 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer
// Description : Directed self-checking bench for frame_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer;

    localparam int unsigned c_depth = 76800;

    logic        pixel_clk;
    logic        arstn;
    logic        wea;
    logic [16:0] addra;
    logic [7:0]  dina;
    logic [16:0] addrb;
    logic [7:0]  doutb;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        clr_req;
    logic [7:0]  clr_color;
    logic        clr_busy;

    int r_checks = 0;
    int r_fails  = 0;

    frame_buffer u_dut (
        .pixel_clk (pixel_clk),
        .arstn     (arstn),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .addrb     (addrb),
        .doutb     (doutb),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .clr_req   (clr_req),
        .clr_color (clr_color),
        .clr_busy  (clr_busy)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 ns after it.
    task automatic tick;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic wr(input logic [16:0] a, input logic [7:0] d);
        wea   = 1'b1;
        addra = a;
        dina  = d;
        tick();
        wea   = 1'b0;
    endtask

    task automatic rd(input logic [16:0] a);
        addrb = a;
        tick();
    endtask

    int n;

    initial begin
        arstn     = 1'b0;
        wea       = 1'b0;
        addra     = '0;
        dina      = '0;
        addrb     = '0;
        clr_req   = 1'b0;
        clr_color = '0;

        // Reset state
        tick();
        tick();
        check("rst_doutb", doutb, 8'h00);
        check("rst_rgb", {red, green, blue}, 12'h000);
        check("rst_busy", clr_busy, 1'b0);
        arstn = 1'b1;
        tick();

        // Corner pixels and channel decode
        wr(17'd0, 8'hE0);
        wr(17'd76799, 8'h1C);
        rd(17'd0);
        check("rd0", doutb, 8'hE0);
        check("rd0_rgb", {red, green, blue}, 12'hE00);
        rd(17'd76799);
        check("rd_last", doutb, 8'h1C);
        check("rd_last_green", green, 4'hE);

        // Blue channel at (x=5, y=130)
        wr(17'd41605, 8'h03);
        rd(17'd41605);
        check("blue_px", {red, green, blue}, 12'h00C);

        // Out-of-range writes dropped, out-of-range reads return zero
        wr(17'd76800, 8'hFF);
        wr(17'd131071, 8'hFF);
        rd(17'd76800);
        check("oor_rd", doutb, 8'h00);
        rd(17'd131071);
        check("oor_rd_max", doutb, 8'h00);
        rd(17'd0);
        check("oor_keep0", doutb, 8'hE0);
        rd(17'd76799);
        check("oor_keep_last", doutb, 8'h1C);

        // Read-first on a same-address collision
        wr(17'd100, 8'h11);
        addrb = 17'd100;
        wr(17'd100, 8'h22);
        check("rw_old", doutb, 8'h11);
        tick();
        check("rw_new", doutb, 8'h22);

        // Full clear, with a user write landing in the accepting cycle
        clr_color = 8'h01;
        clr_req   = 1'b1;
        wea       = 1'b1;
        addra     = 17'd200;
        dina      = 8'h55;
        tick();
        clr_req   = 1'b0;
        wea       = 1'b0;
        clr_color = 8'hF0;
        n = 0;
        while (clr_busy && n < 80000) begin
            n++;
            if (n == 100) begin
                // Dropped user write and an ignored second request
                wea     = 1'b1;
                addra   = 17'd5;
                dina    = 8'hAA;
                clr_req = 1'b1;
            end else begin
                wea     = 1'b0;
                clr_req = 1'b0;
            end
            tick();
        end
        wea     = 1'b0;
        clr_req = 1'b0;
        check("clr_cycles", n, c_depth);
        rd(17'd0);
        check("clr_0", doutb, 8'h01);
        rd(17'd38400);
        check("clr_mid", doutb, 8'h01);
        rd(17'd76799);
        check("clr_last", doutb, 8'h01);
        rd(17'd5);
        check("clr_drop_wr", doutb, 8'h01);
        rd(17'd200);
        check("clr_over_wr", doutb, 8'h01);

        // Abort a clear with reset after 1000 fill writes
        wr(17'd999, 8'h66);
        wr(17'd1000, 8'h77);
        clr_color = 8'h3C;
        clr_req   = 1'b1;
        addrb     = 17'd999;
        tick();
        clr_req = 1'b0;
        check("abort_busy_on", clr_busy, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            tick();
        end
        check("abort_rd_during", doutb, 8'h66);
        arstn = 1'b0;
        tick();
        check("abort_busy", clr_busy, 1'b0);
        check("abort_doutb", doutb, 8'h00);
        arstn = 1'b1;
        rd(17'd999);
        check("abort_999", doutb, 8'h3C);
        rd(17'd1000);
        check("abort_1000", doutb, 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", r_checks, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
